// File: rtl/key_event_pkg.sv
// key_event_pkg: shared FSM encodings, repeat-count width and count helper for key_event_gen
package key_event_pkg;

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        AUTO     = 2'd3
    } key_state_t;

    localparam int REP_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [REP_CNT_W-1:0] sat_inc(input logic [REP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/key_evt_timer.sv
// key_evt_timer: up-counter with sync clear and a terminal-count compare against a supplied limit
module key_evt_timer #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Clear has priority over increment so a reload on terminal count restarts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign tc = (count == term);

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: turns a debounced key level into PRESS/RELEASE/typematic REPEAT events
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int CNT_W        = 12,
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 KEY_IN,
    output logic                 PRESS,
    output logic                 RELEASE,
    output logic                 REPEAT,
    output logic                 HELD,
    output logic [REP_CNT_W-1:0] REP_CNT,
    output logic [1:0]           STATE
);

    key_state_t       state;
    logic             key_active;
    logic             tc;
    logic             tmr_clr;
    logic             tmr_inc;
    logic [CNT_W-1:0] term;

    // The timer only runs while the key is down; it restarts on press, on every repeat and on release from AUTO
    assign key_active = (state == PRESSED) || (state == AUTO);
    assign tmr_inc    = key_active && KEY_IN && !tc;
    assign tmr_clr    = ((state == IDLE) && KEY_IN) || (key_active && KEY_IN && tc) || ((state == AUTO) && !KEY_IN);
    assign term       = (state == AUTO) ? CNT_W'(REPEAT_TICKS - 1) : CNT_W'(LONG_TICKS - 1);
    assign STATE      = state;

    key_evt_timer #(.CNT_W(CNT_W)) u_timer (
        .clk  (CLK),
        .rst  (RESET),
        .clr  (tmr_clr),
        .inc  (tmr_inc),
        .term (term),
        .tc   (tc)
    );

    // Event FSM; release is tested before terminal count so it always wins over a repeat
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= WAIT_REL;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            REPEAT  <= 1'b0;
            HELD    <= 1'b0;
            REP_CNT <= '0;
        end else begin
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            REPEAT  <= 1'b0;
            case (state)
                WAIT_REL: begin
                    if (!KEY_IN)
                        state <= IDLE;
                end
                IDLE: begin
                    if (KEY_IN) begin
                        state   <= PRESSED;
                        PRESS   <= 1'b1;
                        REP_CNT <= '0;
                    end
                end
                PRESSED: begin
                    if (!KEY_IN) begin
                        state   <= IDLE;
                        RELEASE <= 1'b1;
                    end else if (tc) begin
                        state   <= AUTO;
                        REPEAT  <= 1'b1;
                        HELD    <= 1'b1;
                        REP_CNT <= sat_inc(REP_CNT);
                    end
                end
                AUTO: begin
                    if (!KEY_IN) begin
                        state   <= IDLE;
                        RELEASE <= 1'b1;
                        HELD    <= 1'b0;
                    end else if (tc) begin
                        REPEAT  <= 1'b1;
                        REP_CNT <= sat_inc(REP_CNT);
                    end
                end
                default: state <= WAIT_REL;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed checks of key_event_gen with LONG_TICKS=8, REPEAT_TICKS=4
module tb_key_event_gen;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       KEY_IN = 1'b0;
    logic       PRESS, RELEASE, REPEAT, HELD;
    logic [7:0] REP_CNT;
    logic [1:0] STATE;

    int checks = 0;
    int errors = 0;

    key_event_gen #(.CNT_W(12), .LONG_TICKS(8), .REPEAT_TICKS(4)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .KEY_IN  (KEY_IN),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .REPEAT  (REPEAT),
        .HELD    (HELD),
        .REP_CNT (REP_CNT),
        .STATE   (STATE)
    );

    always #5 CLK = ~CLK;

    // Drive KEY_IN at a falling edge, let one rising edge sample it, observe at the next falling edge
    task automatic step(input logic k);
        KEY_IN = k;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset(input logic k);
        @(negedge CLK);
        KEY_IN = k;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        checks++;
        if ({PRESS, RELEASE, REPEAT, HELD, REP_CNT, STATE} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got P%b R%b Rp%b H%b cnt=%0d st=%0d, want all 0", PRESS, RELEASE, REPEAT, HELD, REP_CNT, STATE);
        end
    endtask

    task automatic test_auto_repeat;
        logic exp_rep, exp_held;
        step(1'b0);
        step(1'b0);
        checks++;
        if (STATE !== 2'd1) begin
            errors++;
            $display("FAIL idle_after_wait: state=%0d want 1", STATE);
        end
        step(1'b1);
        checks++;
        if (PRESS !== 1'b1 || STATE !== 2'd2 || REP_CNT !== 8'd0) begin
            errors++;
            $display("FAIL press_e0: press=%b state=%0d cnt=%0d want 1 2 0", PRESS, STATE, REP_CNT);
        end
        for (int i = 1; i < 20; i++) begin
            step(1'b1);
            exp_rep  = (i == 8) || (i == 12) || (i == 16);
            exp_held = (i >= 8);
            checks++;
            if ({PRESS, RELEASE, REPEAT, HELD} !== {1'b0, 1'b0, exp_rep, exp_held}) begin
                errors++;
                $display("FAIL repeat_e%0d: P/R/Rp/H=%b%b%b%b want 00%b%b", i, PRESS, RELEASE, REPEAT, HELD, exp_rep, exp_held);
            end
        end
        checks++;
        if (REP_CNT !== 8'd3 || STATE !== 2'd3) begin
            errors++;
            $display("FAIL repeat_count: cnt=%0d state=%0d want 3 3", REP_CNT, STATE);
        end
    endtask

    task automatic test_release_auto;
        do_reset(1'b0);
        step(1'b0);
        step(1'b1);
        for (int i = 1; i < 14; i++) step(1'b1);
        step(1'b0);
        checks++;
        if ({RELEASE, REPEAT, PRESS, HELD} !== 4'b1000 || STATE !== 2'd1 || REP_CNT !== 8'd2) begin
            errors++;
            $display("FAIL release_e14: R/Rp/P/H=%b%b%b%b state=%0d cnt=%0d want 1000 1 2", RELEASE, REPEAT, PRESS, HELD, STATE, REP_CNT);
        end
        step(1'b0);
        checks++;
        if (RELEASE !== 1'b0 || REP_CNT !== 8'd2) begin
            errors++;
            $display("FAIL release_single: release=%b cnt=%0d want 0 2", RELEASE, REP_CNT);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1);
        checks++;
        if (PRESS !== 1'b1 || RELEASE !== 1'b0 || REP_CNT !== 8'd0) begin
            errors++;
            $display("FAIL b2b_press: press=%b release=%b cnt=%0d want 1 0 0", PRESS, RELEASE, REP_CNT);
        end
        step(1'b0);
        checks++;
        if (PRESS !== 1'b0 || RELEASE !== 1'b1 || REP_CNT !== 8'd0 || STATE !== 2'd1) begin
            errors++;
            $display("FAIL b2b_release: press=%b release=%b cnt=%0d state=%0d want 0 1 0 1", PRESS, RELEASE, REP_CNT, STATE);
        end
    endtask

    task automatic test_release_at_tc;
        step(1'b1);
        for (int i = 1; i < 8; i++) step(1'b1);
        step(1'b0);
        checks++;
        if ({RELEASE, REPEAT, HELD} !== 3'b100 || REP_CNT !== 8'd0 || STATE !== 2'd1) begin
            errors++;
            $display("FAIL release_at_tc: R/Rp/H=%b%b%b cnt=%0d state=%0d want 100 0 1", RELEASE, REPEAT, HELD, REP_CNT, STATE);
        end
        step(1'b0);
        checks++;
        if ({RELEASE, REPEAT, HELD} !== 3'b000) begin
            errors++;
            $display("FAIL after_tc_release: R/Rp/H=%b%b%b want 000", RELEASE, REPEAT, HELD);
        end
    endtask

    task automatic test_held_through_reset;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            checks++;
            if (PRESS !== 1'b0 || STATE !== 2'd0) begin
                errors++;
                $display("FAIL held_reset_%0d: press=%b state=%0d want 0 0", i, PRESS, STATE);
            end
        end
        step(1'b0);
        checks++;
        if (RELEASE !== 1'b0 || STATE !== 2'd1) begin
            errors++;
            $display("FAIL held_reset_release: release=%b state=%0d want 0 1", RELEASE, STATE);
        end
        step(1'b1);
        checks++;
        if (PRESS !== 1'b1) begin
            errors++;
            $display("FAIL held_reset_press: press=%b want 1", PRESS);
        end
        step(1'b1);
        checks++;
        if (PRESS !== 1'b0) begin
            errors++;
            $display("FAIL held_reset_single: press=%b want 0", PRESS);
        end
        step(1'b0);
    endtask

    task automatic test_saturation;
        int   exp_cnt;
        logic exp_rep;
        do_reset(1'b0);
        step(1'b0);
        step(1'b1);
        exp_cnt = 0;
        for (int i = 1; i < 1100; i++) begin
            step(1'b1);
            exp_rep = (i >= 8) && ((i - 8) % 4 == 0);
            if (exp_rep && exp_cnt < 255) exp_cnt++;
            checks++;
            if (REPEAT !== exp_rep || REP_CNT !== 8'(exp_cnt) || HELD !== (i >= 8)) begin
                errors++;
                $display("FAIL sat_e%0d: rep=%b cnt=%0d held=%b want %b %0d %b", i, REPEAT, REP_CNT, HELD, exp_rep, exp_cnt, i >= 8);
            end
        end
        checks++;
        if (REP_CNT !== 8'd255) begin
            errors++;
            $display("FAIL sat_final: cnt=%0d want 255", REP_CNT);
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({PRESS, RELEASE, REPEAT, HELD, REP_CNT, STATE} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: P%b R%b Rp%b H%b cnt=%0d st=%0d want all 0", PRESS, RELEASE, REPEAT, HELD, REP_CNT, STATE);
        end
        @(negedge CLK);
        RESET = 1'b0;
        step(1'b1);
        checks++;
        if ({PRESS, RELEASE, REPEAT} !== 3'b000 || STATE !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_held: P/R/Rp=%b%b%b state=%0d want 000 0", PRESS, RELEASE, REPEAT, STATE);
        end
        step(1'b0);
        checks++;
        if (RELEASE !== 1'b0 || STATE !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_release: release=%b state=%0d want 0 1", RELEASE, STATE);
        end
    endtask

    initial begin
        test_reset();
        test_auto_repeat();
        test_release_auto();
        test_back_to_back();
        test_release_at_tc();
        test_held_through_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
